iir_df2_param: RTL and testbench
================================

Name: iir_df2_param

Overview:
- Parametrised direct-form-II IIR filter. Successor to the fixed first-order a0/a1/b0/b1 filter; drop-in replacement inside the DIN/VIN to DOUT/VOUT data path, between the data source and the data sink.
- Filter order, data width and accumulator guard bits are generic.
- Coefficients are not static ports: they are written at runtime into a double-buffered bank and committed atomically.
- Adds a bypass mode and a sticky saturation flag.

Parameters:
- NB, 8: data and coefficient width, two's complement Q1.(NB-1).
- ORD, 2: filter order, legal range 1..4.
- GB, 4: accumulator guard bits.
- CW, clog2(2*ORD+1): width of the coefficient index.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  reset, asynchronous, active-low.
- DIN  in  NB  input sample.
- VIN  in  1  DIN valid, one sample per cycle when high.
- BYPASS  in  1  1 = DOUT is a delayed copy of DIN, filter state frozen.
- COEF_WE  in  1  write COEF_DATA into shadow bank.
- COEF_SEL  in  CW  shadow index: 0 = b0, 1..ORD = b1..bORD, ORD+1..2*ORD = a1..aORD.
- COEF_DATA  in  NB  coefficient value, Q1.(NB-1).
- COEF_SWAP  in  1  pulse: copy shadow bank to active bank.
- DOUT  out  NB  filtered sample.
- VOUT  out  1  DOUT valid.
- SAT_FLAG  out  1  sticky, set on any saturation of w or y.

Behaviour:
- Clocking: one clock CLK. Reset RST_n is asynchronous and active-low.
- Reset: asynchronous, active-low. All registers cleared: DOUT=0, VOUT=0, SAT_FLAG=0, delay line w[1..ORD]=0, shadow and active coefficients=0, input stage=0.
- Pipeline:
  - Edge k: DIN/VIN/BYPASS registered into x_r/v_r/byp_r.
  - Cycle k+1: combinational compute.
  - Edge k+1: DOUT/VOUT registered.
  - Latency 2 clocks: VIN high in cycle n gives VOUT high in cycle n+2. Throughput 1 sample per clock.
- Arithmetic, computed when v_r=1 and byp_r=0:
  - fb = (sum over k=1..ORD of a_k*w[k]) >>> (NB-1). Products are full 2*NB bits, the accumulator is 2*NB+GB bits, >>> is arithmetic shift (floor).
  - w0 = x_r - fb, saturated to NB bits.
  - y = (b0*w0 + sum over k=1..ORD of b_k*w[k]) >>> (NB-1), saturated to NB bits.
  - Saturation clamps to +(2^(NB-1)-1) or -2^(NB-1).
  - Either saturation sets SAT_FLAG. SAT_FLAG is cleared only by reset.
- State update: delay line shifts (w[1] <= w0, w[k] <= w[k-1]) only on an edge where v_r=1 and byp_r=0. Otherwise it holds. VIN gaps therefore do not advance the filter.
- VOUT <= v_r. DOUT updates only when v_r=1 and holds otherwise.
- Bypass: when v_r=1 and byp_r=1, DOUT <= x_r with the same 2-cycle latency. The delay line holds and SAT_FLAG is unaffected. Toggling BYPASS mid-stream is glitch-free because it is sampled with the data.
- Coefficient bank:
  - COEF_WE writes shadow[COEF_SEL] at the edge.
  - COEF_SEL > 2*ORD: write ignored.
  - COEF_SWAP copies the pre-edge shadow contents to active. A write in the same cycle lands in shadow only and is not committed.
  - A sample computed in the swap cycle uses the old active set; the following sample uses the new set.
  - The delay line is not cleared on swap.
- Reset mid-operation: everything clears immediately and asynchronously, including in-flight samples (VOUT drops in the same cycle). Coefficients must be reloaded.

Decomposition:
- Shared package iir_pkg holds:
  - NB/ORD/GB defaults;
  - coefficient index constants (IDX_B0, IDX_B(k), IDX_A(k));
  - a saturate function (wide to NB bits, returns value plus an overflow bit).
- One sub-module, iir_coef_bank:
  - contains the shadow and active register arrays, write decode and swap;
  - exposes flat active b0..bORD and a1..aORD buses.
- Datapath, delay line and output register stay in iir_df2_param.

Test Plan:
- Reset: hold RST_n=0 with random inputs → DOUT=0, VOUT=0, SAT_FLAG=0. Assert RST_n=0 while samples are in flight → VOUT=0 in the same cycle.
- Bypass (NB=8): BYPASS=1, VIN=1, DIN=37 in cycle 0 → DOUT=37 with VOUT=1 in cycle 2. Delay line stays zero, checked by a following filtered impulse.
- FIR gain: write b0=64 (0.5), swap. Input 100 → DOUT=50. Input -100 → DOUT=-50.
- Recursion: b0=64, a1=-64, ORD≥1, swap. Impulse 100,0,0,0 → DOUT 50,25,12,6. Insert a VIN=0 gap after the second sample → same sequence, only delayed.
- Saturation: b0=127, b1=127, a=0. Inputs 127,127 → DOUT 126 then 127 (clamped), SAT_FLAG=1 and sticky afterwards.
- Swap timing: stream constant 100 with b0=64. In the same cycle write shadow b0=32 and pulse COEF_SWAP → outputs stay 50 (the write is not committed). A later swap → outputs become 25 from the next sample. A write with COEF_SEL=2*ORD+1 has no effect.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the parametrised direct-form-II IIR filter:
// defaults, coefficient index map and the saturation helper.
package iir_pkg;

  localparam int NB_DEF  = 8;
  localparam int ORD_DEF = 2;
  localparam int GB_DEF  = 4;

  // Saturation works on a fixed wide word; callers sign-extend into it.
  localparam int SAT_W = 64;

  localparam int IDX_B0 = 0;

  function automatic int idx_b(input int k);
    return k;
  endfunction

  function automatic int idx_a(input int ord, input int k);
    return ord + k;
  endfunction

  typedef struct packed {
    logic signed [SAT_W-1:0] value;
    logic                    ovf;
  } sat_t;

  // Clamp x to the signed nb-bit range and flag whether clamping happened.
  function automatic sat_t saturate(input logic signed [SAT_W-1:0] x, input int nb);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_t                    r;
    hi      = (64'sd1 <<< (nb - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    r.value = x;
    r.ovf   = 1'b0;
    if (x > hi) begin
      r.value = hi;
      r.ovf   = 1'b1;
    end else if (x < lo) begin
      r.value = lo;
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient storage: runtime writes land in the shadow bank,
// a swap pulse commits the whole set to the active bank in one edge.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int NB  = NB_DEF,
  parameter int ORD = ORD_DEF,
  parameter int CW  = $clog2(2*ORD+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [CW-1:0]         sel,
  input  logic [NB-1:0]         data,
  input  logic                  swap,
  output logic [(ORD+1)*NB-1:0] b_flat,
  output logic [ORD*NB-1:0]     a_flat
);

  localparam int NC = 2*ORD + 1;

  logic [NB-1:0] shadow [NC];
  logic [NB-1:0] active [NC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a RAM, so clearing them in reset is cheap and required.
      for (int i = 0; i < NC; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (we && (sel <= CW'(NC - 1))) begin
        shadow[sel] <= data;
      end
      // NOTE: non-blocking assignment makes active take the pre-edge shadow, so a same-cycle write is not committed.
      if (swap) begin
        for (int i = 0; i < NC; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  for (genvar k = 0; k <= ORD; k++) begin : g_b
    assign b_flat[k*NB +: NB] = active[idx_b(k)];
  end

  for (genvar k = 1; k <= ORD; k++) begin : g_a
    assign a_flat[(k-1)*NB +: NB] = active[idx_a(ORD, k)];
  end

endmodule

// File: rtl/iir_df2_param.sv
// Parametrised direct-form-II IIR filter with bypass, sticky saturation flag
// and a double-buffered runtime coefficient bank. Latency 2, one sample/clock.
module iir_df2_param
  import iir_pkg::*;
#(
  parameter int NB  = NB_DEF,
  parameter int ORD = ORD_DEF,
  parameter int GB  = GB_DEF,
  parameter int CW  = $clog2(2*ORD+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [NB-1:0] din,
  input  logic                 vin,
  input  logic                 bypass,
  input  logic                 coef_we,
  input  logic [CW-1:0]        coef_sel,
  input  logic signed [NB-1:0] coef_data,
  input  logic                 coef_swap,
  output logic signed [NB-1:0] dout,
  output logic                 vout,
  output logic                 sat_flag
);

  localparam int ACC_W = 2*NB + GB;

  logic [(ORD+1)*NB-1:0] b_flat;
  logic [ORD*NB-1:0]     a_flat;

  iir_coef_bank #(
    .NB  (NB),
    .ORD (ORD),
    .CW  (CW)
  ) u_coef_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (coef_we),
    .sel    (coef_sel),
    .data   (coef_data),
    .swap   (coef_swap),
    .b_flat (b_flat),
    .a_flat (a_flat)
  );

  logic signed [NB-1:0] b_c [0:ORD];
  logic signed [NB-1:0] a_c [1:ORD];

  for (genvar k = 0; k <= ORD; k++) begin : g_b_unpack
    assign b_c[k] = b_flat[k*NB +: NB];
  end

  for (genvar k = 1; k <= ORD; k++) begin : g_a_unpack
    assign a_c[k] = a_flat[(k-1)*NB +: NB];
  end

  logic signed [NB-1:0] x_r;
  logic                 v_r;
  logic                 byp_r;
  logic signed [NB-1:0] w [1:ORD];

  logic signed [ACC_W-1:0] fb_acc;
  logic signed [ACC_W-1:0] fb_sh;
  logic signed [ACC_W-1:0] y_acc;
  logic signed [ACC_W-1:0] y_sh;
  sat_t                    w0_sat;
  sat_t                    y_sat;
  logic signed [NB-1:0]    w0;
  logic signed [NB-1:0]    y;

  // NOTE: every always_comb output is assigned before any conditional use, so no latch can be inferred.
  always_comb begin
    fb_acc = '0;
    for (int k = 1; k <= ORD; k++) begin
      fb_acc += ACC_W'(a_c[k] * w[k]);
    end
    fb_sh  = fb_acc >>> (NB - 1);
    w0_sat = saturate(SAT_W'(x_r) - SAT_W'(fb_sh), NB);
    w0     = w0_sat.value[NB-1:0];

    y_acc = ACC_W'(b_c[0] * w0);
    for (int k = 1; k <= ORD; k++) begin
      y_acc += ACC_W'(b_c[k] * w[k]);
    end
    y_sh  = y_acc >>> (NB - 1);
    y_sat = saturate(SAT_W'(y_sh), NB);
    y     = y_sat.value[NB-1:0];
  end

  // Only the clamped low NB bits of the wide saturation words carry information.
  logic unused_sat_bits;
  assign unused_sat_bits = ^{w0_sat.value[SAT_W-1:NB], y_sat.value[SAT_W-1:NB]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r      <= '0;
      v_r      <= 1'b0;
      byp_r    <= 1'b0;
      dout     <= '0;
      vout     <= 1'b0;
      sat_flag <= 1'b0;
      for (int k = 1; k <= ORD; k++) begin
        w[k] <= '0;
      end
    end else begin
      x_r   <= din;
      v_r   <= vin;
      byp_r <= bypass;
      vout  <= v_r;
      if (v_r) begin
        if (byp_r) begin
          dout <= x_r;
        end else begin
          dout     <= y;
          sat_flag <= sat_flag | w0_sat.ovf | y_sat.ovf;
          w[1]     <= w0;
          for (int k = 2; k <= ORD; k++) begin
            w[k] <= w[k-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_df2_param.sv
// Self-checking bench for iir_df2_param: table-driven vectors feed a scoreboard
// queue that a negedge monitor drains; hand sequences cover reset and swap timing.
module tb_iir_df2_param;

  localparam int NB  = 8;
  localparam int ORD = 2;
  localparam int GB  = 4;
  localparam int CW  = $clog2(2*ORD+1);

  localparam int SEL_B0 = 0;
  localparam int SEL_B1 = 1;
  localparam int SEL_A1 = ORD + 1;
  localparam int SEL_BAD = 2*ORD + 1;

  logic                 clk;
  logic                 rst_n;
  logic signed [NB-1:0] din;
  logic                 vin;
  logic                 bypass;
  logic                 coef_we;
  logic [CW-1:0]        coef_sel;
  logic signed [NB-1:0] coef_data;
  logic                 coef_swap;
  logic signed [NB-1:0] dout;
  logic                 vout;
  logic                 sat_flag;

  iir_df2_param #(
    .NB  (NB),
    .ORD (ORD),
    .GB  (GB),
    .CW  (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .vin       (vin),
    .bypass    (bypass),
    .coef_we   (coef_we),
    .coef_sel  (coef_sel),
    .coef_data (coef_data),
    .coef_swap (coef_swap),
    .dout      (dout),
    .vout      (vout),
    .sat_flag  (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [NB-1:0] din;
    logic                 vin;
    logic                 byp;
    logic signed [NB-1:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic signed [NB-1:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // Output monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vout === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vout: got dout %0d with nothing expected at %0t", dout, $time);
      end else begin
        check("dout", dout, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int d, input bit v, input bit b, input int e);
    vec_t r;
    r.din = NB'(d);
    r.vin = v;
    r.byp = b;
    r.exp = NB'(e);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    din       = '0;
    vin       = 1'b0;
    bypass    = 1'b0;
    coef_we   = 1'b0;
    coef_sel  = '0;
    coef_data = '0;
    coef_swap = 1'b0;
  endtask

  // Drive one cycle; any coefficient controls set by the caller apply to this cycle too.
  task automatic send(input vec_t v);
    din    = v.din;
    vin    = v.vin;
    bypass = v.byp;
    if (v.vin) sb.push_back(v.exp);
    step();
    idle_inputs();
  endtask

  task automatic write_coef(input int sel, input int data);
    coef_we   = 1'b1;
    coef_sel  = CW'(sel);
    coef_data = NB'(data);
    step();
    idle_inputs();
  endtask

  task automatic swap_bank();
    coef_swap = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    check(name, sb.size(), 0);
  endtask

  task automatic do_reset(input bit chk);
    rst_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      din       = NB'($urandom);
      vin       = 1'($urandom);
      bypass    = 1'($urandom);
      coef_we   = 1'($urandom);
      coef_sel  = CW'($urandom);
      coef_data = NB'($urandom);
      coef_swap = 1'($urandom);
      step();
    end
    if (chk) begin
      check("rst_dout", dout, 0);
      check("rst_vout", vout, 0);
      check("rst_sat", sat_flag, 0);
    end
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_table(input vec_t t [$]);
    foreach (t[i]) send(t[i]);
  endtask

  initial begin
    vec_t tbl [$];

    idle_inputs();
    rst_n = 1'b0;
    step();

    // Reset held with random inputs.
    do_reset(1'b1);

    // Bypass latency, then a filtered impulse proving the delay line stayed zero.
    write_coef(SEL_B0, 64);
    write_coef(SEL_B1, 64);
    swap_bank();
    din    = 8'sd37;
    vin    = 1'b1;
    bypass = 1'b1;
    sb.push_back(8'sd37);
    step();
    check("byp_vout_c1", vout, 0);
    idle_inputs();
    step();
    check("byp_vout_c2", vout, 1);
    check("byp_dout_c2", dout, 37);
    tbl = '{mk(100, 1, 0, 50), mk(0, 1, 0, 50), mk(0, 1, 0, 0)};
    run_table(tbl);
    drain("byp_drain");

    // Pure FIR gain 0.5.
    do_reset(1'b0);
    write_coef(SEL_B0, 64);
    swap_bank();
    tbl = '{mk(100, 1, 0, 50), mk(-100, 1, 0, -50), mk(0, 1, 0, 0),
            mk(127, 1, 0, 63), mk(-128, 1, 0, -64)};
    run_table(tbl);
    drain("fir_drain");
    check("fir_sat", sat_flag, 0);

    // First-order recursion, contiguous and with a VIN gap.
    do_reset(1'b0);
    write_coef(SEL_B0, 64);
    write_coef(SEL_A1, -64);
    swap_bank();
    tbl = '{mk(100, 1, 0, 50), mk(0, 1, 0, 25), mk(0, 1, 0, 12), mk(0, 1, 0, 6)};
    run_table(tbl);
    drain("rec_drain");
    do_reset(1'b0);
    write_coef(SEL_B0, 64);
    write_coef(SEL_A1, -64);
    swap_bank();
    tbl = '{mk(100, 1, 0, 50), mk(0, 1, 0, 25), mk(55, 0, 0, 0), mk(55, 0, 0, 0),
            mk(0, 1, 0, 12), mk(0, 1, 0, 6)};
    run_table(tbl);
    drain("gap_drain");

    // Saturation and sticky flag.
    do_reset(1'b0);
    write_coef(SEL_B0, 127);
    write_coef(SEL_B1, 127);
    swap_bank();
    tbl = '{mk(127, 1, 0, 126)};
    run_table(tbl);
    drain("sat_pre_drain");
    check("sat_pre", sat_flag, 0);
    tbl = '{mk(127, 1, 0, 127), mk(0, 1, 0, 126), mk(0, 1, 0, 0)};
    run_table(tbl);
    drain("sat_drain");
    check("sat_sticky", sat_flag, 1);

    // Reset while samples are in flight: VOUT drops at once, flag clears.
    tbl = '{mk(10, 1, 1, 10), mk(20, 1, 1, 20)};
    run_table(tbl);
    check("inflight_vout_pre", vout, 1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("inflight_vout", vout, 0);
    check("inflight_dout", dout, 0);
    check("inflight_sat", sat_flag, 0);
    step();
    rst_n = 1'b1;
    step();

    // Swap timing: same-cycle write is not committed, later swap takes effect.
    write_coef(SEL_B0, 64);
    swap_bank();
    for (int i = 0; i < 3; i++) send(mk(100, 1, 0, 50));
    coef_we   = 1'b1;
    coef_sel  = CW'(SEL_B0);
    coef_data = 8'sd32;
    coef_swap = 1'b1;
    send(mk(100, 1, 0, 50));
    for (int i = 0; i < 3; i++) send(mk(100, 1, 0, 50));
    coef_swap = 1'b1;
    send(mk(100, 1, 0, 25));
    for (int i = 0; i < 2; i++) send(mk(100, 1, 0, 25));
    write_coef(SEL_BAD, 127);
    swap_bank();
    for (int i = 0; i < 2; i++) send(mk(100, 1, 0, 25));
    drain("swap_drain");
    check("swap_sat", sat_flag, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
